animation_sequencer: RTL and testbench
======================================

# animation_sequencer

Frame-locked controller for the start-of-game intro animation. Counts VGA frames (vsync falling edges) once the game is started and produces the `animation` flag and step `counter` consumed by the ladder/platform animation stages directly downstream. When all steps are shown it raises a one-cycle done pulse and a level game-enable for the gameplay logic.

## Interface
- STEPS, 8: number of animation steps; `counter` runs 0..STEPS-1.
- FRAMES_PER_STEP, 30: frames each step is held; must be ≥1.
- CNT_W, 4: width of `counter`; must satisfy 2^CNT_W ≥ STEPS.
- clk  in  1  pixel clock, 65 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- start_game  in  1  level; high requests and sustains the game session.
- vsync  in  1  vsync from the timing stage feeding the animation chain.
- animation  out  1  high while the intro animation is running.
- counter  out  CNT_W  current step index, valid while `animation` is high.
- anim_done  out  1  one-cycle pulse when the last step completes.
- game_active  out  1  high from completion until `start_game` drops.

## Operation
- Edge detect: `vs_q` registers `vsync`. `frame_tick` = `vs_q & ~vsync`, i.e. the first clk edge that samples vsync low after high.
- Internal frame counter `fcnt`, width ceil(log2(FRAMES_PER_STEP)), minimum 1.
- States:
  - IDLE: all outputs 0, `fcnt`=0. If `start_game`=1, go to ARMED.
  - ARMED: wait for `frame_tick`. On the tick, go to RUN with `animation`=1, `counter`=0, `fcnt`=0. This aligns the animation to a frame boundary.
  - RUN: on each `frame_tick`:
    - If `fcnt` < FRAMES_PER_STEP-1: `fcnt`++.
    - Else: `fcnt`=0. If `counter` < STEPS-1, `counter`++. Otherwise go to DONE, with `animation`=0, `anim_done`=1 for that one cycle, and `game_active`=1.
  - DONE: `counter` holds STEPS-1, `anim_done`=0, `game_active`=1. When `start_game`=0, go to IDLE.
- Abort: `start_game`=0 in ARMED or RUN forces IDLE on the next edge and clears all outputs. The abort takes priority over a simultaneous `frame_tick`.
- Restart: re-entry from IDLE always starts at `counter`=0. No state is retained across sessions.
- `counter` never exceeds STEPS-1. No wrap-around occurs.
- If STEPS=1, RUN lasts exactly FRAMES_PER_STEP ticks.

## Timing
- Async reset sets state=IDLE, `vs_q`=1, `fcnt`=0, and all outputs 0. Outputs are registered.
- Resetting `vs_q` to 1 means a vsync already low at reset release counts as a tick. This is intended.
- `start_game` rise to ARMED: 1 cycle.
- `animation` rises on the clk edge where `frame_tick` is first true in ARMED, one edge after vsync goes low.
- Each `counter` increment occurs on the `frame_tick` edge, so downstream stages see the new step during vsync (blanking). The step is stable for the whole visible frame.
- Total RUN duration: STEPS×FRAMES_PER_STEP ticks.
- `anim_done` and the fall of `animation` happen on the same edge as the final tick. `game_active` rises on that same edge.
- `start_game` fall to outputs low: 1 cycle.
- Reset asserted mid-RUN clears outputs immediately, asynchronously.

## Test plan
- Use STEPS=3, FRAMES_PER_STEP=2, CNT_W=2, with vsync driven as a short frame (≥4 clk high, ≥2 low) for all scenarios.
- Reset and idle: `rst_n` low with `start_game`=0 and vsync toggling -> `animation`=0, `counter`=0, `game_active`=0, no `anim_done` for 5 frames.
- Full run: raise `start_game` mid-frame -> `animation` rises on the next vsync negedge. `counter` reads 0,0,1,1,2,2 across successive frames. On the 6th tick, `anim_done` pulses for exactly 1 cycle, `animation`=0 and `game_active`=1. `counter` stays 2.
- Abort: drop `start_game` while `counter`=1 -> the next edge gives `animation`=0 and `counter`=0 with no `anim_done`. Re-raising it restarts from `counter`=0 after the next negedge.
- Simultaneous: drop `start_game` on the same cycle as a `frame_tick` in RUN -> IDLE, outputs 0, no increment or done.
- Async reset mid-RUN: pulse `rst_n` low between clock edges at `counter`=2 -> outputs 0 before the next clk edge. After release with `start_game`=1, the sequence restarts from ARMED.
- Done hold/exit: after completion, keep `start_game`=1 for 4 frames -> `game_active` stays 1 and `anim_done` does not repeat. Drop `start_game` -> `game_active`=0 after 1 cycle.

Source files
------------

// File: rtl/animation_sequencer.sv
// animation_sequencer
// Frame-locked intro animation controller. Once the game is started it
// waits for a vsync falling edge, then steps `counter` through 0..STEPS-1,
// holding each step for FRAMES_PER_STEP frames. After the last step it
// pulses `anim_done` and holds `game_active` until `start_game` drops.
// Dropping `start_game` at any point returns to IDLE with all outputs low.
// All outputs are registered. `state_dbg` exposes the FSM state for
// checkers.

module animation_sequencer #(
    parameter int STEPS           = 8,
    parameter int FRAMES_PER_STEP = 30,
    parameter int CNT_W           = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_game,
    input  logic             vsync,
    output logic             animation,
    output logic [CNT_W-1:0] counter,
    output logic             anim_done,
    output logic             game_active,
    output logic [1:0]       state_dbg
);

    // Width of the per-step frame counter. It is at least 1 bit so that
    // FRAMES_PER_STEP = 1 still elaborates cleanly.
    localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [FW-1:0]    FCNT_LAST = FW'(FRAMES_PER_STEP - 1);
    localparam logic [FW-1:0]    FCNT_ONE  = FW'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic             vs_q;
    logic             frame_tick;
    logic [FW-1:0]    fcnt, fcnt_n;
    logic [CNT_W-1:0] counter_n;
    logic             animation_n;
    logic             anim_done_n;
    logic             game_active_n;

    // vs_q resets high, so a vsync already low when reset releases is
    // seen as a frame boundary.
    assign frame_tick = vs_q & ~vsync;
    assign state_dbg  = state;

    // Register vsync for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q <= 1'b1;
        end else begin
            vs_q <= vsync;
        end
    end

    // State, frame counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fcnt        <= '0;
            counter     <= '0;
            animation   <= 1'b0;
            anim_done   <= 1'b0;
            game_active <= 1'b0;
        end else begin
            state       <= state_n;
            fcnt        <= fcnt_n;
            counter     <= counter_n;
            animation   <= animation_n;
            anim_done   <= anim_done_n;
            game_active <= game_active_n;
        end
    end

    // Next-state and next-output logic. Losing start_game wins over a
    // simultaneous frame tick in ARMED and RUN.
    always_comb begin
        state_n       = state;
        fcnt_n        = fcnt;
        counter_n     = counter;
        animation_n   = animation;
        anim_done_n   = 1'b0;
        game_active_n = game_active;

        unique case (state)
            IDLE: begin
                fcnt_n        = '0;
                counter_n     = '0;
                animation_n   = 1'b0;
                game_active_n = 1'b0;
                if (start_game) begin
                    state_n = ARMED;
                end
            end

            ARMED: begin
                if (!start_game) begin
                    state_n       = IDLE;
                    fcnt_n        = '0;
                    counter_n     = '0;
                    animation_n   = 1'b0;
                    game_active_n = 1'b0;
                end else if (frame_tick) begin
                    state_n     = RUN;
                    fcnt_n      = '0;
                    counter_n   = '0;
                    animation_n = 1'b1;
                end
            end

            RUN: begin
                if (!start_game) begin
                    state_n       = IDLE;
                    fcnt_n        = '0;
                    counter_n     = '0;
                    animation_n   = 1'b0;
                    game_active_n = 1'b0;
                end else if (frame_tick) begin
                    if (fcnt < FCNT_LAST) begin
                        fcnt_n = fcnt + FCNT_ONE;
                    end else begin
                        fcnt_n = '0;
                        if (counter < CNT_LAST) begin
                            counter_n = counter + CNT_ONE;
                        end else begin
                            state_n       = DONE;
                            animation_n   = 1'b0;
                            anim_done_n   = 1'b1;
                            game_active_n = 1'b1;
                        end
                    end
                end
            end

            DONE: begin
                counter_n     = CNT_LAST;
                animation_n   = 1'b0;
                game_active_n = 1'b1;
                if (!start_game) begin
                    state_n       = IDLE;
                    fcnt_n        = '0;
                    counter_n     = '0;
                    game_active_n = 1'b0;
                end
            end

            default: begin
                state_n       = IDLE;
                fcnt_n        = '0;
                counter_n     = '0;
                animation_n   = 1'b0;
                game_active_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_animation_sequencer.sv
// tb_animation_sequencer
// Scenario bench for animation_sequencer with STEPS=3, FRAMES_PER_STEP=2.
// Each frame drives vsync high for FR_HI cycles and low for FR_LO cycles.
// The expected output word {anim_done, game_active, animation, counter}
// is queued as each cycle's stimulus is driven and popped once the DUT
// has updated, #1 after the clock edge.

module tb_animation_sequencer;

    localparam int STEPS = 3;
    localparam int FPS   = 2;
    localparam int CNT_W = 2;
    localparam int FR_HI = 5;
    localparam int FR_LO = 3;
    localparam int W     = 5;

    logic             clk;
    logic             rst_n;
    logic             start_game;
    logic             vsync;
    logic             animation;
    logic [CNT_W-1:0] counter;
    logic             anim_done;
    logic             game_active;
    logic [1:0]       state_dbg;

    logic [W-1:0] exp_q[$];
    int           n_vec;
    int           n_err;

    animation_sequencer #(
        .STEPS           (STEPS),
        .FRAMES_PER_STEP (FPS),
        .CNT_W           (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_game  (start_game),
        .vsync       (vsync),
        .animation   (animation),
        .counter     (counter),
        .anim_done   (anim_done),
        .game_active (game_active),
        .state_dbg   (state_dbg)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack an expected/observed output word.
    function automatic logic [W-1:0] pk(input logic d, input logic g,
                                        input logic a, input logic [1:0] c);
        return {d, g, a, c};
    endfunction

    // Single comparison point.
    task automatic check_val(input string tag, input logic [W-1:0] got,
                             input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got done/act/anim/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d",
                     tag, got[4], got[3], got[2], got[1:0],
                     exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    // Pop the oldest expectation and compare it with the DUT outputs.
    task automatic compare_out(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, pk(anim_done, game_active, animation, counter), e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One vsync frame. At cycle sg_idx start_game is set to sg_val and the
    // expectation becomes sg_exp; on the first low cycle (the tick) it
    // becomes tick_exp, after which the done bit is expected to clear.
    task automatic frame(input string tag, input logic [W-1:0] pre,
                         input logic [W-1:0] tick_exp, input int sg_idx,
                         input logic sg_val, input logic [W-1:0] sg_exp);
        logic [W-1:0] cur;
        cur = pre;
        for (int idx = 0; idx < FR_HI + FR_LO; idx++) begin
            vsync = (idx < FR_HI);
            if (idx == sg_idx) begin
                start_game = sg_val;
                cur        = sg_exp;
            end
            if (idx == FR_HI) cur = tick_exp;
            exp_q.push_back(cur);
            step();
            compare_out(tag);
            if (idx == FR_HI) cur[4] = 1'b0;
        end
    endtask

    // Plain frame with no start_game change.
    task automatic frame_n(input string tag, input logic [W-1:0] pre,
                           input logic [W-1:0] tick_exp);
        frame(tag, pre, tick_exp, -1, 1'b0, pre);
    endtask

    logic [W-1:0] z;
    logic [W-1:0] r0, r1, r2, dn, dh;

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        start_game = 1'b0;
        vsync      = 1'b1;
        z  = pk(0, 0, 0, 2'd0);
        r0 = pk(0, 0, 1, 2'd0);
        r1 = pk(0, 0, 1, 2'd1);
        r2 = pk(0, 0, 1, 2'd2);
        dn = pk(1, 1, 0, 2'd2);
        dh = pk(0, 1, 0, 2'd2);

        // Reset held with vsync toggling: everything stays low.
        for (int i = 0; i < 5; i++) frame_n("reset_hold", z, z);
        vsync = 1'b1;
        step();
        rst_n = 1'b1;
        // Idle after release, start_game low.
        frame_n("idle", z, z);
        frame_n("idle", z, z);

        // Full run: start mid-frame, animation rises on the next tick.
        frame("run_entry", z, r0, 2, 1'b1, z);
        frame_n("run_t1", r0, r0);
        frame_n("run_t2", r0, r1);
        frame_n("run_t3", r1, r1);
        frame_n("run_t4", r1, r2);
        frame_n("run_t5", r2, r2);
        frame_n("run_done", r2, dn);
        // Done hold: game_active stays, no repeat of anim_done.
        for (int i = 0; i < 4; i++) frame_n("done_hold", dh, dh);
        // Done exit: outputs low one cycle after start_game falls.
        frame("done_exit", dh, z, 2, 1'b0, z);

        // Abort at counter=1, then restart from counter 0.
        frame("ab_entry", z, r0, 0, 1'b1, z);
        frame_n("ab_t1", r0, r0);
        frame_n("ab_t2", r0, r1);
        frame("abort", r1, z, 2, 1'b0, z);
        frame("restart", z, r0, 1, 1'b1, z);
        frame_n("rs_t1", r0, r0);
        frame_n("rs_t2", r0, r1);
        frame_n("rs_t3", r1, r1);
        frame_n("rs_t4", r1, r2);
        frame_n("rs_t5", r2, r2);
        // Drop start_game on the final tick: abort wins, no done pulse.
        frame("simul", r2, z, FR_HI, 1'b0, r2);
        frame_n("simul_after", z, z);

        // Async reset mid-RUN at counter=2.
        frame("ar_entry", z, r0, 0, 1'b1, z);
        frame_n("ar_t1", r0, r0);
        frame_n("ar_t2", r0, r1);
        frame_n("ar_t3", r1, r1);
        frame_n("ar_t4", r1, r2);
        vsync = 1'b1;
        exp_q.push_back(r2);
        step();
        compare_out("ar_pre");
        #2;
        rst_n = 1'b0;
        exp_q.push_back(z);
        #1;
        compare_out("ar_async");
        #1;
        rst_n = 1'b1;
        // start_game still high: ARMED again, next tick re-enters RUN.
        frame_n("ar_rearm", z, r0);
        frame_n("ar_rs_t1", r0, r0);
        frame_n("ar_rs_t2", r0, r1);
        frame("ar_exit", r1, z, 0, 1'b0, z);

        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL leftover %0d expectations", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
